// File: rtl/comp_sync_gen.sv
// Composite sync generator: sequences the vertical interval and produces registered active-low csync.
// Define COMP_SYNC_EQ_EN to enable pre/post equalization lines around the serration lines.
module comp_sync_gen #(
  parameter int unsigned EQ_LINES     = 3,
  parameter int unsigned SERR_LINES   = 3,
  parameter logic [8:0]  VS_LINE_NTSC = 9'd13,
  parameter logic [8:0]  VS_LINE_PAL  = 9'd300,
  parameter logic [9:0]  HS_W         = 10'd37,
  parameter logic [9:0]  EQ_W         = 10'd18
) (
  input  logic       clk_dot4x,
  input  logic       rst_n,
  input  logic [1:0] chip,
  input  logic [9:0] raster_x,
  input  logic [8:0] raster_y,
  input  logic       se,
  output logic       csync,
  output logic       vsync_active,
  output logic [1:0] line_type
);

  localparam logic [1:0] CHIP6567R8   = 2'd0;
  localparam logic [1:0] CHIP6569R3   = 2'd1;
  localparam logic [1:0] CHIP6567R56A = 2'd2;
  localparam logic [1:0] CHIP6569R1   = 2'd3;

  localparam logic [2:0] EQ_LAST   = 3'(EQ_LINES - 1);
  localparam logic [2:0] SERR_LAST = 3'(SERR_LINES - 1);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_PRE_EQ  = 2'd1,
    ST_SERR    = 2'd2,
    ST_POST_EQ = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [9:0] prev_x_q;
  logic [9:0] half_q, half_d;
  logic       csync_q, csync_d;
  logic       vsync_q;
  logic [1:0] line_type_q;

  logic       line_start;
  logic [8:0] vs_line;
  logic [9:0] chip_half;
  logic       eq_pulse;

  always_comb begin
    line_start = (raster_x == '0) && (prev_x_q != '0);
    vs_line    = ((chip == CHIP6567R8) || (chip == CHIP6567R56A)) ? VS_LINE_NTSC : VS_LINE_PAL;

    chip_half = 10'd252;
    case (chip)
      CHIP6567R8:             chip_half = 10'd260;
      CHIP6567R56A:           chip_half = 10'd256;
      CHIP6569R1, CHIP6569R3: chip_half = 10'd252;
      default:                chip_half = 10'd252;
    endcase

    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;

    if (line_start) begin
      half_d = chip_half;
      case (state_q)
        ST_NORMAL: begin
          if (raster_y == vs_line) begin
`ifdef COMP_SYNC_EQ_EN
            state_d = ST_PRE_EQ;
`else
            state_d = ST_SERR;
`endif
            cnt_d = '0;
          end
        end
        ST_PRE_EQ: begin
          if (cnt_q == EQ_LAST) begin
            state_d = ST_SERR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        ST_SERR: begin
          if (cnt_q == SERR_LAST) begin
`ifdef COMP_SYNC_EQ_EN
            state_d = ST_POST_EQ;
`else
            state_d = ST_NORMAL;
`endif
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        ST_POST_EQ: begin
          if (cnt_q == EQ_LAST) begin
            state_d = ST_NORMAL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: begin
          state_d = ST_NORMAL;
          cnt_d   = '0;
        end
      endcase
    end

    // Pulse shape follows the next state so the first clock of a line already matches its line type.
    eq_pulse = (raster_x < EQ_W) || ((raster_x >= half_d) && (raster_x < half_d + EQ_W));
    csync_d  = 1'b1;
    case (state_d)
      ST_NORMAL:  csync_d = !(raster_x < HS_W);
      ST_SERR:    csync_d = se;
      ST_PRE_EQ,
      ST_POST_EQ: csync_d = !eq_pulse;
      default:    csync_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_NORMAL;
      cnt_q       <= '0;
      prev_x_q    <= '0;
      half_q      <= 10'd260;
      csync_q     <= 1'b1;
      vsync_q     <= 1'b0;
      line_type_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_x_q    <= raster_x;
      half_q      <= half_d;
      csync_q     <= csync_d;
      vsync_q     <= (state_d != ST_NORMAL);
      line_type_q <= state_d;
    end
  end

  assign csync        = csync_q;
  assign vsync_active = vsync_q;
  assign line_type    = line_type_q;

endmodule

// File: tb/tb_comp_sync_gen.sv
// Bench for comp_sync_gen: per-line vector table driven clock by clock, with a csync/state scoreboard.
// Expected line types follow the COMP_SYNC_EQ_EN setting of the build.
module tb_comp_sync_gen;

  localparam logic [1:0] R8   = 2'd0;
  localparam logic [1:0] R3   = 2'd1;
  localparam logic [1:0] R56A = 2'd2;

`ifdef COMP_SYNC_EQ_EN
  localparam logic [1:0] SEQ [0:9] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
`else
  localparam logic [1:0] SEQ [0:9] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] chip = R8;
  logic [9:0] raster_x = '0;
  logic [8:0] raster_y = '0;
  logic       se = 1'b1;
  logic       csync;
  logic       vsync_active;
  logic [1:0] line_type;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [8:0] y;
    logic [1:0] chip;
    logic [1:0] lt;
    int         chg_x;
    logic [1:0] chg_chip;
    int         rst_x;
  } line_t;

  typedef struct {
    logic       cs;
    logic [1:0] lt;
    logic [9:0] x;
    logic [8:0] y;
  } exp_t;

  line_t tbl[$];
  exp_t  sb[$];

  comp_sync_gen #(
    .EQ_LINES(3),
    .SERR_LINES(3),
    .VS_LINE_NTSC(9'd13),
    .VS_LINE_PAL(9'd300),
    .HS_W(10'd37),
    .EQ_W(10'd18)
  ) dut (
    .clk_dot4x(clk),
    .rst_n(rst_n),
    .chip(chip),
    .raster_x(raster_x),
    .raster_y(raster_y),
    .se(se),
    .csync(csync),
    .vsync_active(vsync_active),
    .line_type(line_type)
  );

  always #5 clk = ~clk;

  function automatic int half_of(input logic [1:0] c);
    if (c == R8) return 260;
    if (c == R56A) return 256;
    return 252;
  endfunction

  function automatic logic se_of(input int x, input int h);
    return !(((x >= h - 36) && (x < h)) || ((x >= 2 * h - 36) && (x < 2 * h)));
  endfunction

  function automatic logic cs_of(input int x, input logic [1:0] t, input int h, input logic s);
    case (t)
      2'd0:    return !(x < 37);
      2'd2:    return s;
      default: return !((x < 18) || ((x >= h) && (x < h + 18)));
    endcase
  endfunction

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp,
                     input logic [9:0] x, input logic [8:0] y);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at y=%0d x=%0d: got %0d, expected %0d", name, y, x, act, exp);
    end
  endtask

  task automatic tick(input int x, input int y, input logic [1:0] c, input logic s,
                      input logic exp_cs, input logic [1:0] exp_lt);
    exp_t e;
    exp_t got;
    raster_x = 10'(x);
    raster_y = 9'(y);
    chip     = c;
    se       = s;
    e.cs = exp_cs; e.lt = exp_lt; e.x = 10'(x); e.y = 9'(y);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("csync", {1'b0, csync}, {1'b0, got.cs}, got.x, got.y);
    chk("line_type", line_type, got.lt, got.x, got.y);
    chk("vsync_active", {1'b0, vsync_active}, {1'b0, got.lt != 2'd0}, got.x, got.y);
  endtask

  task automatic run_line(input line_t r);
    int         w;
    int         h;
    logic [1:0] c;
    logic [1:0] t;
    logic       s;
    logic       in_rst;
    h = half_of(r.chip);
    w = 2 * h;
    c = r.chip;
    t = r.lt;
    for (int x = 0; x < w; x++) begin
      in_rst = 1'b0;
      if (r.chg_x != 0 && x == r.chg_x) c = r.chg_chip;
      if (r.rst_x != 0 && x == r.rst_x) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst_csync", {1'b0, csync}, 2'd1, 10'(x), r.y);
        chk("async_rst_line_type", line_type, 2'd0, 10'(x), r.y);
        in_rst = 1'b1;
        t = 2'd0;
      end
      s = se_of(x, h);
      for (int k = 0; k < 4; k++)
        tick(x, r.y, c, s, in_rst ? 1'b1 : cs_of(x, t, h, s), t);
      if (in_rst) rst_n = 1'b1;
    end
  endtask

  function automatic void add(input int y, input logic [1:0] c, input logic [1:0] lt,
                              input int chg_x, input logic [1:0] chg_c, input int rst_x);
    line_t r;
    r.y = 9'(y); r.chip = c; r.lt = lt; r.chg_x = chg_x; r.chg_chip = chg_c; r.rst_x = rst_x;
    tbl.push_back(r);
  endfunction

  initial begin
    add(50, R8, 2'd0, 0, R8, 0);
    for (int i = 0; i < 10; i++) add(13 + i, R8, SEQ[i], 0, R8, 0);
    add(299, R3, 2'd0, 0, R3, 0);
    for (int i = 0; i < 10; i++) add(300 + i, R3, SEQ[i], 0, R3, 0);
    add(13, R8,   SEQ[0], 0,   R8,   0);
    add(14, R8,   SEQ[1], 100, R56A, 0);
    add(15, R56A, SEQ[2], 0,   R56A, 0);
    add(16, R56A, SEQ[3], 0,   R56A, 0);
    add(17, R56A, SEQ[4], 0,   R56A, 240);
    add(18, R56A, 2'd0,   0,   R56A, 0);
    add(13, R56A, SEQ[0], 0,   R56A, 0);

    #2 rst_n = 1'b0;
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 4; k++)
        tick(i * 13, 13 + (i % 3) * 287, R8, 1'b1, 1'b1, 2'd0);
    end
    raster_x = '0;
    raster_y = 9'd50;
    rst_n = 1'b1;

    foreach (tbl[i]) run_line(tbl[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
